// File: rtl/yarp_pkg.sv
// Shared definitions for the yarp decode stage.
// Holds the RV32I base opcodes, the instruction format enum, the decoded
// instruction record carried by the output register, and the opcode to
// format lookup used by the decoder.
package yarp_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYS    = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } instr_fmt_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_type;
    logic        i_type;
    logic        s_type;
    logic        b_type;
    logic        u_type;
    logic        j_type;
    logic [31:0] imm;
    logic        illegal;
  } decoded_instr_t;

  function automatic instr_fmt_t opcode_fmt(input logic [6:0] op);
    instr_fmt_t fmt;
    case (op)
      OP_R:                           fmt = FMT_R;
      OP_LOAD, OP_IMM, OP_JALR, OP_SYS: fmt = FMT_I;
      OP_STORE:                       fmt = FMT_S;
      OP_BRANCH:                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:               fmt = FMT_U;
      OP_JAL:                         fmt = FMT_J;
      default:                        fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/yarp_decode_stage_if.sv
// Handshake bundles around the decode stage.
// yarp_fetch_if : fetch -> decode (instr_valid_i/instr_ready_o, instr_i, pc_i).
//   master = fetch side, slave = decode stage.
// yarp_dec_if   : decode -> execute (dec_valid_o/dec_ready_i plus decoded fields).
//   master = decode stage, slave = execute side.
// Member names are written from the decode stage's point of view.
interface yarp_fetch_if #(parameter int PC_W = 32);
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;

  modport master (output instr_valid_i, output instr_i, output pc_i, input instr_ready_o);
  modport slave  (input instr_valid_i, input instr_i, input pc_i, output instr_ready_o);
endinterface

interface yarp_dec_if #(parameter int PC_W = 32);
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [PC_W-1:0] pc_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [6:0]      op_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic            r_type_o;
  logic            i_type_o;
  logic            s_type_o;
  logic            b_type_o;
  logic            u_type_o;
  logic            j_type_o;
  logic [31:0]     imm_o;
  logic            illegal_o;

  modport master (
    output dec_valid_o, output pc_o, output rs1_o, output rs2_o, output rd_o,
    output op_o, output funct3_o, output funct7_o,
    output r_type_o, output i_type_o, output s_type_o, output b_type_o,
    output u_type_o, output j_type_o, output imm_o, output illegal_o,
    input  dec_ready_i
  );
  modport slave (
    input  dec_valid_o, input pc_o, input rs1_o, input rs2_o, input rd_o,
    input  op_o, input funct3_o, input funct7_o,
    input  r_type_o, input i_type_o, input s_type_o, input b_type_o,
    input  u_type_o, input j_type_o, input imm_o, input illegal_o,
    output dec_ready_i
  );
endinterface

// File: rtl/yarp_instr_fifo.sv
// Synchronous instruction buffer.
// Ports: clk, reset_n (async active-low), flush_i (sync clear, wins over
// push/pop), push_i/din_i (ignored when full), pop_i (ignored when empty),
// dout_o (head entry), full_o, empty_o.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module yarp_instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/yarp_decode_stage.sv
// RV32I decode stage between fetch and execute.
// Ports: clk, reset_n (async active-low), flush_i (sync, drops everything
// buffered and the instruction offered in the same cycle), fetch (slave side
// of yarp_fetch_if), dec (master side of yarp_dec_if).
// Fetched words are buffered in yarp_instr_fifo; the head is decoded
// combinationally and captured by the output register whenever that register
// is empty or being consumed.
module yarp_decode_stage
  import yarp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int PC_W        = 32,
  parameter int ILLEGAL_CHK = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush_i,
  yarp_fetch_if.slave fetch,
  yarp_dec_if.master  dec
);

  localparam int EW = 32 + PC_W;

  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_dout;
  logic [31:0]     h_instr;
  logic [PC_W-1:0] h_pc;
  logic            push, load;
  instr_fmt_t      fmt;

  decoded_instr_t  dec_q, dec_d;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  // Held low through reset so instr_ready_o stays 0 until the first edge after release.
  logic            run_q;

  assign fetch.instr_ready_o = run_q && !fifo_full;
  assign push = fetch.instr_valid_i && fetch.instr_ready_o;
  assign load = !fifo_empty && (!valid_q || dec.dec_ready_i);
  assign {h_instr, h_pc} = fifo_dout;

  yarp_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .push_i  (push),
    .din_i   ({fetch.instr_i, fetch.pc_i}),
    .pop_i   (load),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    dec_d        = '0;
    dec_d.rs1    = h_instr[19:15];
    dec_d.rs2    = h_instr[24:20];
    dec_d.rd     = h_instr[11:7];
    dec_d.op     = h_instr[6:0];
    dec_d.funct3 = h_instr[14:12];
    dec_d.funct7 = h_instr[31:25];
    fmt = opcode_fmt(h_instr[6:0]);
    if (h_instr[1:0] != 2'b11) fmt = FMT_ILL;
    if (fmt == FMT_ILL) dec_d.illegal = (ILLEGAL_CHK != 0);
    case (fmt)
      FMT_R: dec_d.r_type = 1'b1;
      FMT_I: begin
        dec_d.i_type = 1'b1;
        dec_d.imm    = {{20{h_instr[31]}}, h_instr[31:20]};
      end
      FMT_S: begin
        dec_d.s_type = 1'b1;
        dec_d.imm    = {{20{h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
      end
      FMT_B: begin
        dec_d.b_type = 1'b1;
        dec_d.imm    = {{19{h_instr[31]}}, h_instr[31], h_instr[7],
                        h_instr[30:25], h_instr[11:8], 1'b0};
      end
      FMT_U: begin
        dec_d.u_type = 1'b1;
        dec_d.imm    = {h_instr[31:12], 12'h000};
      end
      FMT_J: begin
        dec_d.j_type = 1'b1;
        dec_d.imm    = {{11{h_instr[31]}}, h_instr[31], h_instr[19:12],
                        h_instr[20], h_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else begin
      run_q <= 1'b1;
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        dec_q   <= dec_d;
        pc_q    <= h_pc;
      end else if (dec.dec_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dec.dec_valid_o = valid_q;
  assign dec.pc_o        = pc_q;
  assign dec.rs1_o       = dec_q.rs1;
  assign dec.rs2_o       = dec_q.rs2;
  assign dec.rd_o        = dec_q.rd;
  assign dec.op_o        = dec_q.op;
  assign dec.funct3_o    = dec_q.funct3;
  assign dec.funct7_o    = dec_q.funct7;
  assign dec.r_type_o    = dec_q.r_type;
  assign dec.i_type_o    = dec_q.i_type;
  assign dec.s_type_o    = dec_q.s_type;
  assign dec.b_type_o    = dec_q.b_type;
  assign dec.u_type_o    = dec_q.u_type;
  assign dec.j_type_o    = dec_q.j_type;
  assign dec.imm_o       = dec_q.imm;
  assign dec.illegal_o   = dec_q.illegal;

endmodule
